// File: rtl/fused_fp_pkg.sv
// fused_fp_pkg: shared definitions for the pipelined fused significand multiplier.
//   - CONFIG_* lane-mode codes carried alongside every operand pair
//   - lane significand widths (hidden bit included) and lane bit strides
//   - prod_t    : raw per-lane products held between stage 1 and the last stage
//   - payload_t : normalised result held in the output stage
// Optional feature macro honoured by the design: FUSED_MUL_STICKY_EN.
package fused_fp_pkg;

    typedef enum logic [1:0] {
        CONFIG_FP8  = 2'd0,
        CONFIG_FP16 = 2'd1,
        CONFIG_FP32 = 2'd2,
        CONFIG_RSVD = 2'd3
    } cfg_e;

    // Significand widths per lane, hidden bit included.
    localparam int W32 = 24;
    localparam int W16 = 11;
    localparam int W8  = 4;

    // Lane n of a mode starts at bit n*STRIDE; FP32 has a single lane at bit 0.
    localparam int FP16_STRIDE = 16;
    localparam int FP8_STRIDE  = 8;

    // Full-width products of every lane layout, computed in stage 1.
    typedef struct packed {
        cfg_e                    cfg;
        logic [2*W32-1:0]        p32;
        logic [1:0][2*W16-1:0]   p16;
        logic [3:0][2*W8-1:0]    p8;
    } prod_t;

    // Normalised result leaving the pipe.
    typedef struct packed {
        logic [31:0] mant;
        logic [3:0]  carry;
        logic [3:0]  sticky;
        logic        err;
        cfg_e        cfg;
    } payload_t;

endpackage

// File: rtl/fp_mul_pipe_8_16_32_lane_norm.sv
// fused_lane_norm: normalises one lane's 2W-bit significand product.
//   p_i      : full product of two W-bit significands (each in [1,2) or 0)
//   mant_o   : W-bit truncated, normalised significand
//   carry_o  : 1 when the product is >= 2.0 (exponent must increment)
//   sticky_o : OR of the discarded low product bits; tied 0 unless
//              FUSED_MUL_STICKY_EN is defined, in which case the OR-tree exists.
module fused_lane_norm #(
    parameter int W = 24
) (
    input  logic [2*W-1:0] p_i,
    output logic [W-1:0]   mant_o,
    output logic           carry_o,
    output logic           sticky_o
);

    // Product of two values in [1,2) lies in [1,4): the top bit decides
    // whether the binary point moves one place.
    assign carry_o = p_i[2*W-1];
    assign mant_o  = carry_o ? p_i[2*W-1:W] : p_i[2*W-2:W-1];

`ifdef FUSED_MUL_STICKY_EN
    assign sticky_o = carry_o ? (|p_i[W-1:0]) : (|p_i[W-2:0]);
`else
    // Without the sticky feature the low product bits are simply dropped.
    logic unused_low_bits;
    assign unused_low_bits = ^p_i[W-2:0];
    assign sticky_o        = 1'b0;
`endif

endmodule

// File: rtl/fp_mul_pipe_8_16_32.sv
// fp_mul_pipe_8_16_32: pipelined lane-parallel significand multiplier.
// One 32-bit operand pair per cycle as 1xFP32, 2xFP16 or 4xFP8 significands.
// Optional feature macro: FUSED_MUL_STICKY_EN (builds the per-lane sticky OR).
//
// Parameters: STAGES (1..4) pipeline depth = latency in cycles.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake; in_cfg lane mode, in_a/in_b operands
//   out_valid/out_ready output handshake
//   out_mant            packed normalised products (input lane layout)
//   out_carry           per-lane product >= 2.0
//   out_sticky          per-lane OR of discarded bits (0 without the macro)
//   out_err             result came from the reserved cfg code
//   inflight            registered count of valid pipeline entries
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The whole pipe advances together when en = out_ready | ~out_valid,
// and in_ready = en, so in_ready depends combinationally on out_ready.
// Bubbles travel with the pipe; output data holds while stalled.
module fp_mul_pipe_8_16_32
    import fused_fp_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_cfg,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_mant,
    output logic [3:0]  out_carry,
    output logic [3:0]  out_sticky,
    output logic        out_err,
    output logic [2:0]  inflight
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("fp_mul_pipe_8_16_32: STAGES must be in 1..4");
    end

    logic en;
    logic in_xfer;
    logic out_xfer;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign in_xfer  = in_valid & en;
    assign out_xfer = out_valid & out_ready;

    // ---------------------------------------------------------------
    // Stage 1 multiply: every lane layout is multiplied in parallel;
    // unused operand bits never reach a multiplier.
    // ---------------------------------------------------------------
    prod_t prod_in;

    always_comb begin
        prod_in     = '0;
        prod_in.cfg = cfg_e'(in_cfg);
        prod_in.p32 = (2*W32)'(in_a[W32-1:0]) * (2*W32)'(in_b[W32-1:0]);
        for (int i = 0; i < 2; i++) begin
            prod_in.p16[i] = (2*W16)'(in_a[FP16_STRIDE*i +: W16])
                           * (2*W16)'(in_b[FP16_STRIDE*i +: W16]);
        end
        for (int i = 0; i < 4; i++) begin
            prod_in.p8[i] = (2*W8)'(in_a[FP8_STRIDE*i +: W8])
                          * (2*W8)'(in_b[FP8_STRIDE*i +: W8]);
        end
    end

    logic unused_in_bits;
    assign unused_in_bits = ^{in_a[31:28], in_b[31:28]};

    // ---------------------------------------------------------------
    // Product stages 1..STAGES-1 (none when STAGES=1, where multiply and
    // normalisation share the single stage).
    // ---------------------------------------------------------------
    prod_t norm_src;
    logic  norm_v;

    if (STAGES == 1) begin : g_single
        assign norm_src = prod_in;
        assign norm_v   = in_valid;
    end else begin : g_pipe
        prod_t             prod_q [STAGES-1];
        logic [STAGES-2:0] pv_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pv_q <= '0;
                for (int s = 0; s < STAGES-1; s++) begin
                    prod_q[s] <= '0;
                end
            end else if (en) begin
                pv_q[0]   <= in_valid;
                prod_q[0] <= prod_in;
                for (int s = 1; s < STAGES-1; s++) begin
                    pv_q[s]   <= pv_q[s-1];
                    prod_q[s] <= prod_q[s-1];
                end
            end
        end

        assign norm_src = prod_q[STAGES-2];
        assign norm_v   = pv_q[STAGES-2];
    end

    // ---------------------------------------------------------------
    // Normalisation: 7 lane normalisers, selected by the captured cfg.
    // ---------------------------------------------------------------
    logic [W32-1:0]       m32;
    logic                 c32, s32;
    logic [1:0][W16-1:0]  m16;
    logic [1:0]           c16, s16;
    logic [3:0][W8-1:0]   m8;
    logic [3:0]           c8, s8;

    fused_lane_norm #(.W(W32)) u_norm32 (
        .p_i      (norm_src.p32),
        .mant_o   (m32),
        .carry_o  (c32),
        .sticky_o (s32)
    );

    for (genvar g = 0; g < 2; g++) begin : g_norm16
        fused_lane_norm #(.W(W16)) u_norm16 (
            .p_i      (norm_src.p16[g]),
            .mant_o   (m16[g]),
            .carry_o  (c16[g]),
            .sticky_o (s16[g])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_norm8
        fused_lane_norm #(.W(W8)) u_norm8 (
            .p_i      (norm_src.p8[g]),
            .mant_o   (m8[g]),
            .carry_o  (c8[g]),
            .sticky_o (s8[g])
        );
    end

    payload_t norm_d;

    always_comb begin
        norm_d     = '0;
        norm_d.cfg = norm_src.cfg;
        case (norm_src.cfg)
            CONFIG_FP32: begin
                norm_d.mant[W32-1:0] = m32;
                norm_d.carry[0]      = c32;
                norm_d.sticky[0]     = s32;
            end
            CONFIG_FP16: begin
                for (int i = 0; i < 2; i++) begin
                    norm_d.mant[FP16_STRIDE*i +: W16] = m16[i];
                    norm_d.carry[i]                   = c16[i];
                    norm_d.sticky[i]                  = s16[i];
                end
            end
            CONFIG_FP8: begin
                for (int i = 0; i < 4; i++) begin
                    norm_d.mant[FP8_STRIDE*i +: W8] = m8[i];
                    norm_d.carry[i]                 = c8[i];
                    norm_d.sticky[i]                = s8[i];
                end
            end
            default: begin
                // Reserved code: zero result, flagged, still delivered in order.
                norm_d.err = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output stage (stage STAGES) and in-flight counter.
    // ---------------------------------------------------------------
    payload_t   out_q;
    logic       out_v_q;
    logic [2:0] inflight_q;
    logic [2:0] inflight_d;

    always_comb begin
        inflight_d = inflight_q;
        if (in_xfer && !out_xfer) begin
            inflight_d = inflight_q + 3'd1;
        end else if (out_xfer && !in_xfer) begin
            inflight_d = inflight_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            out_v_q    <= 1'b0;
            inflight_q <= 3'd0;
        end else begin
            inflight_q <= inflight_d;
            if (en) begin
                out_v_q <= norm_v;
                // Data only moves on real entries; bubbles leave it untouched.
                if (norm_v) begin
                    out_q <= norm_d;
                end
            end
        end
    end

    logic unused_out_cfg;
    assign unused_out_cfg = ^out_q.cfg;

    assign out_valid  = out_v_q;
    assign out_mant   = out_q.mant;
    assign out_carry  = out_q.carry;
    assign out_sticky = out_q.sticky;
    assign out_err    = out_q.err;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_fp_mul_pipe_8_16_32.sv
// tb_fp_mul_pipe_8_16_32: directed vectors with hand-computed products.
// Driver tasks push the expected response into exp_q on each input
// transfer; an independent monitor pops and compares on each output transfer.
// Expected sticky bits follow FUSED_MUL_STICKY_EN as built.
module tb_fp_mul_pipe_8_16_32;

    localparam int STAGES = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cfg;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mant;
    logic [3:0]  out_carry;
    logic [3:0]  out_sticky;
    logic        out_err;
    logic [2:0]  inflight;

    int checks = 0;
    int errors = 0;

    // {mant[31:0], carry[3:0], sticky[3:0], err}
    logic [40:0] exp_q[$];

    fp_mul_pipe_8_16_32 #(.STAGES(STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cfg     (in_cfg),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_carry  (out_carry),
        .out_sticky (out_sticky),
        .out_err    (out_err),
        .inflight   (inflight)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [3:0] stk(input logic [3:0] s);
`ifdef FUSED_MUL_STICKY_EN
        return s;
`else
        return s & 4'b0000;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Present one pair from a negedge, wait (bounded) for in_ready, then let
    // the transfer edge pass. in_valid stays high so calls chain back-to-back.
    task automatic send(input logic [1:0] cfg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] em, input logic [3:0] ec, input logic [3:0] es,
                        input logic ee);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_cfg   = cfg;
        in_a     = a;
        in_b     = b;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high at %0t", $time);
        end else begin
            exp_q.push_back({em, ec, stk(es), ee});
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [40:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none at %0t", out_mant, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_mant",   64'(out_mant),   64'(e[40:9]));
                    check("out_carry",  64'(out_carry),  64'(e[8:5]));
                    check("out_sticky", 64'(out_sticky), 64'(e[4:1]));
                    check("out_err",    64'(out_err),    64'(e[0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cfg    = 2'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_inflight",  64'(inflight),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_mant",  64'(out_mant),  64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_out_err",   64'(out_err),   64'd0);

        // Latency: accepted on one edge, visible two edges later.
        send(2'd2, 32'h00C0_0000, 32'h00C0_0000, 32'h0090_0000, 4'b0001, 4'b0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("lat_cycle2_valid", 64'(out_valid), 64'd1);
        drain("drain_latency");

        // Back-to-back mixed modes, mode changes every transaction.
        send(2'd2, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 4'b0000, 4'b0000, 1'b0);
        send(2'd1, 32'h0400_0600, 32'h0400_0600, 32'h0400_0480, 4'b0001, 4'b0000, 1'b0);
        send(2'd0, 32'h0808_0F0C, 32'h0C08_0F0C, 32'h0C08_0E09, 4'b0011, 4'b0010, 1'b0);
        send(2'd2, 32'h00FF_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFE, 4'b0001, 4'b0001, 1'b0);
        send(2'd2, 32'h0080_0001, 32'h0080_0000, 32'h0080_0001, 4'b0000, 4'b0000, 1'b0);
        send(2'd0, 32'h0909_0909, 32'h0F0F_0F0F, 32'h0808_0808, 4'b1111, 4'b1111, 1'b0);
        send(2'd0, 32'h0000_0008, 32'h0808_0808, 32'h0000_0008, 4'b0000, 4'b0000, 1'b0);
        send(2'd1, 32'hFC00_FE00, 32'h0400_0600, 32'h0400_0480, 4'b0001, 4'b0000, 1'b0);
        send(2'd2, 32'hFFC0_0000, 32'hABC0_0000, 32'h0090_0000, 4'b0001, 4'b0000, 1'b0);
        send(2'd3, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1);
        idle();
        drain("drain_mixed");

        // Backpressure: 4 back-to-back pairs, consumer stalled for 6 cycles.
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                send(2'd2, 32'h00C0_0000, 32'h00C0_0000, 32'h0090_0000, 4'b0001, 4'b0000, 1'b0);
                send(2'd2, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 4'b0000, 4'b0000, 1'b0);
                send(2'd1, 32'h0400_0600, 32'h0400_0600, 32'h0400_0480, 4'b0001, 4'b0000, 1'b0);
                send(2'd0, 32'h0808_0F0C, 32'h0C08_0F0C, 32'h0C08_0E09, 4'b0011, 4'b0010, 1'b0);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                check("bp_in_ready",  64'(in_ready),  64'd0);
                check("bp_inflight",  64'(inflight),  64'(STAGES));
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_hold_mant", 64'(out_mant),  64'h0090_0000);
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        @(negedge clk);
        #1;
        check("bp_end_inflight", 64'(inflight),  64'd0);
        check("bp_end_valid",    64'(out_valid), 64'd0);

        // Asynchronous reset with two entries in flight.
        @(negedge clk);
        out_ready = 1'b0;
        send(2'd2, 32'h00C0_0000, 32'h00C0_0000, 32'h0090_0000, 4'b0001, 4'b0000, 1'b0);
        send(2'd0, 32'h0909_0909, 32'h0F0F_0F0F, 32'h0808_0808, 4'b1111, 4'b1111, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_inflight", 64'(inflight), 64'd2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_inflight",  64'(inflight),  64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        check("arst_out_mant",  64'(out_mant),  64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Reserved cfg after reset, then an FP8 pair with no bubble.
        send(2'd3, 32'h00C0_0000, 32'h00C0_0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1);
        send(2'd0, 32'h0808_0F0C, 32'h0C08_0F0C, 32'h0C08_0E09, 4'b0011, 4'b0010, 1'b0);
        idle();
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe_8_16_32.md
# fp_mul_pipe_8_16_32

Pipelined, lane-parallel successor to the combinational fused significand multiplier `fp_mul_8_16_32`. One 32-bit operand pair is accepted per cycle as 1×FP32, 2×FP16 or 4×FP8 (E4M3) significands, with the hidden bit included. Each lane's truncated, normalised product is returned together with a per-lane exponent-carry flag. It sits between operand unpacking and exponent/rounding logic in the fused FP datapath and uses valid/ready handshakes on both sides.

## Interface
- `STAGES`, default 2: pipeline depth and latency in cycles. Legal range 1..4; any other value is an elaboration error.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: an operand pair is presented.
- `in_ready` output, 1 bit: the block accepts the pair this cycle.
- `in_cfg` input, 2 bits: lane mode. Codes: `CONFIG_FP8`=0, `CONFIG_FP16`=1, `CONFIG_FP32`=2; 3 is reserved.
- `in_a`, `in_b` input, 32 bits each: packed significands in the lane layout below.
- `out_valid` output, 1 bit: a result is presented.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `out_mant` output, 32 bits: packed normalised products, same lane layout as the inputs.
- `out_carry` output, 4 bits: per lane, 1 when the product is ≥2.0 (exponent +1).
- `out_sticky` output, 4 bits: per lane, OR of the discarded product bits. See Configuration.
- `out_err` output, 1 bit: the result came from the reserved `in_cfg` code.
- `inflight` output, 3 bits: number of valid entries in the pipeline (0..STAGES).

## Operation
- Lane layout, identical for inputs and `out_mant`:
  - FP32: lane0 at [23:0].
  - FP16: lane0 at [10:0], lane1 at [26:16].
  - FP8: lanes 0..3 at [3:0], [11:8], [19:16], [27:24].
  - Unused bits are ignored on input and driven 0 on output.
- Per lane with significand width W (24/11/4), form the 2W-bit product P.
  - If P[2W-1]=1: mant = P[2W-1:W], carry=1, sticky = |P[W-1:0].
  - Else: mant = P[2W-2:W-1], carry=0, sticky = |P[W-2:0].
- Truncation only; no rounding happens in this block.
- Lanes that do not exist in the current mode drive carry=0 and sticky=0.
- A zero significand (hidden bit 0) gives P=0, so mant=0 and carry=0. This is not an error.
- Reserved `in_cfg` (3): out_mant=0, out_carry=0, out_sticky=0, out_err=1. The transaction still flows through the pipe in order.
- `in_cfg` is captured with the operands and travels with them. Mode can change on every transaction with no bubble.

## Timing
- Pipeline advance: `en = out_ready | ~out_valid`; `in_ready = en`.
  - This is a combinational path from `out_ready` to `in_ready`, and it is intended.
  - Every stage shifts by one position when `en` is 1 and holds when it is 0.
- A transfer happens when valid & ready are both 1 on a rising edge.
- Latency is exactly STAGES cycles from input transfer to `out_valid` when there is no backpressure. Throughput is 1 per cycle.
- Bubbles advance with the pipe; they are not collapsed.
- Results leave in strict acceptance order.
- `out_*` data is held stable while `out_valid=1` and `out_ready=0`.
- `inflight` counts the stage valid bits and is registered:
  - +1 on an input transfer.
  - −1 on an output transfer.
  - Unchanged when both happen in the same cycle.
  - Never exceeds STAGES.
- Reset (asynchronous assert, synchronous-safe deassert):
  - All stage valid bits cleared; in-flight data is discarded.
  - out_valid=0, out_mant=0, out_carry=0, out_sticky=0, out_err=0, inflight=0.
  - in_ready=1 immediately after reset, since out_valid=0.
- The multiply is placed in stage 1 and normalisation in stage STAGES. When STAGES=1, both happen in one stage.

## Configuration
- Macro: `FUSED_MUL_STICKY_EN`.
- Defined: `out_sticky` is computed as described in Operation.
- Undefined: `out_sticky` is tied to 4'b0000 and the sticky OR-trees are not built. All other behaviour and latency are unchanged.

## Structure
- Package `fused_fp_pkg` holds:
  - the `CONFIG_*` codes;
  - the lane widths (24/11/4) and lane bit offsets;
  - the typedef for a stage payload struct: mant, carry, sticky, err, cfg.
- Sub-module `fused_lane_norm` is parametrised by W. It takes P and returns mant/carry/sticky. There are 7 instances: 1×W24, 2×W11, 4×W4. Their outputs are muxed by cfg.

## Test plan
- STAGES=2, FP32 lane0 a=0xC00000, b=0xC00000 → two cycles later out_mant=0x00900000, carry=0001, sticky=0000.
- FP32 a=0x800000, b=0x800000 → out_mant=0x00800000, carry=0000.
- FP16 a=b=0x04000600 → out_mant=0x04000480, carry=0001.
- FP8 a=0x08080F0C, b=0x0C080F0C → out_mant=0x0C080E09, carry=0011.
  - With `FUSED_MUL_STICKY_EN`: sticky=0010. Without it: sticky=0000.
- Send 4 back-to-back transactions with out_ready=0 for 6 cycles → in_ready drops once inflight=STAGES. After out_ready=1, all 4 results appear in order with none lost or duplicated.
- Assert rst_n low while inflight=2 → out_valid=0 and inflight=0 with no clock edge needed. A later in_cfg=3 transaction returns out_err=1 and out_mant=0.
